swap_seq: RTL and testbench
===========================

SWAP_SEQ -- requirements
Module: swap_seq

Interface
REQ-001 SHALL have parameter AW, default 4: register-index width; the register file holds 2**AW registers.
REQ-002 SHALL have port clk  input  1: single clock; all state changes occur on the falling edge.
REQ-003 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1: swap request, sampled only in IDLE.
REQ-005 SHALL have port reg_a  input  AW: first register index, captured when start is accepted.
REQ-006 SHALL have port reg_b  input  AW: second register index, captured when start is accepted.
REQ-007 SHALL have port bus_sel  output  AW: index of the register driving the 18-bit bus.
REQ-008 SHALL have port bus_oe  output  1: bus_sel is valid; a register drives the bus.
REQ-009 SHALL have port wr_en  output  2**AW: one-hot write enable; register i loads the bus when wr_en[i]=1.
REQ-010 SHALL have port swp_ld  output  1: swap holding register loads the bus.
REQ-011 SHALL have port swp_oe  output  1: swap holding register drives the bus.
REQ-012 SHALL have port busy  output  1: a sequence is in progress.
REQ-013 SHALL have port done  output  1: one-cycle completion pulse.
REQ-014 SHALL have port swap_cnt  output  8: count of completed real swaps.

Function
REQ-015 SHALL implement a Moore FSM with states IDLE, LOAD_T, MOVE_BA, MOVE_TA and DONE; outputs SHALL be decoded from the state and the latched indices only.
REQ-016 In IDLE with start=1 at a falling edge, the FSM SHALL latch reg_a into A and reg_b into B.
REQ-017 On that same edge, the FSM SHALL go to LOAD_T if A!=B, or directly to DONE if A==B.
REQ-018 LOAD_T SHALL drive bus_oe=1, bus_sel=A, swp_ld=1, with all wr_en bits 0, and SHALL proceed to MOVE_BA.
REQ-019 MOVE_BA SHALL drive bus_oe=1, bus_sel=B, wr_en[A]=1, and SHALL proceed to MOVE_TA.
REQ-020 MOVE_TA SHALL drive swp_oe=1, bus_oe=0, wr_en[B]=1, and SHALL proceed to DONE.
REQ-021 DONE SHALL drive done=1 for exactly one cycle and SHALL return to IDLE.
REQ-022 A swap with A!=B SHALL take 4 cycles from start acceptance to done; a swap with A==B SHALL take 1 cycle and SHALL assert no write enable.
REQ-023 busy SHALL be 1 in every state except IDLE; start SHALL be ignored while busy=1, including in DONE.
REQ-024 At most one of bus_oe and swp_oe SHALL be 1 in any cycle, and at most one wr_en bit SHALL be 1 in any cycle.
REQ-025 In IDLE, bus_sel SHALL be 0, and all enables, done and busy SHALL be 0.
REQ-026 swap_cnt SHALL increment by 1 on entry to DONE from MOVE_TA only, and SHALL wrap from 255 to 0.
REQ-027 Changes on reg_a and reg_b after start is accepted SHALL have no effect on the sequence in progress.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, A=0, B=0 and swap_cnt=0, and SHALL drive all outputs low, independent of clk.
REQ-029 Reset asserted mid-sequence SHALL abort the swap with no further write enables; the first start accepted after reset release SHALL begin a fresh sequence.

Configuration
REQ-030 With SWAP_SEQ_CNT_EN defined, the swap_cnt counter SHALL be implemented as in REQ-026.
REQ-031 Without SWAP_SEQ_CNT_EN, swap_cnt SHALL be constant 0 and no counter flops SHALL be present; all other behaviour SHALL be identical.

Verification
REQ-032 After reset, start=1, reg_a=3, reg_b=7 -> the next 4 cycles SHALL show LOAD_T (bus_sel=3, swp_ld), MOVE_BA (bus_sel=7, wr_en[3]), MOVE_TA (swp_oe, wr_en[7]) and DONE (done=1); swap_cnt SHALL then be 1.
REQ-033 start=1, reg_a=reg_b=5 -> done=1 on the next cycle, wr_en SHALL stay 0 throughout, and swap_cnt SHALL be unchanged.
REQ-034 start held high for 10 cycles with reg_a=1, reg_b=2 -> exactly two sequences SHALL run (start re-accepted in the IDLE cycle after DONE), and swap_cnt SHALL increase by 2.
REQ-035 rst pulsed high during MOVE_BA -> all outputs SHALL go to 0 immediately, no wr_en[2] SHALL occur, and swap_cnt SHALL be 0.
REQ-036 256 back-to-back real swaps -> swap_cnt SHALL wrap to 0; repeating the run without SWAP_SEQ_CNT_EN SHALL keep swap_cnt at 0 throughout.
REQ-037 A checker SHALL confirm REQ-024 (at most one bus driver, at most one write enable) every cycle across a run of randomized start, reg_a and reg_b.

Source files
------------

// File: rtl/swap_seq.sv
// swap_seq: register-swap sequencer for a shared 18-bit register-file bus.
// Exchanges the contents of registers A and B through a swap holding register
// in three bus transfers:
//   A -> holding register
//   B -> A
//   holding register -> B
// A swap with A == B completes without any bus transfer.
//
// All state changes happen on the falling edge of clk. The FSM drives its
// outputs from registers that are loaded together with the state. This keeps
// every output a pure function of the current state and the latched indices.
//
// Optional feature: define SWAP_SEQ_CNT_EN to build the 8-bit completed-swap
// counter. Without it, swap_cnt is tied to zero and no counter flops exist.
//
// Ports:
//   clk      in   clock; falling-edge active
//   rst      in   asynchronous, active-high reset
//   start    in   swap request; sampled only in IDLE
//   reg_a    in   first register index; captured when start is accepted
//   reg_b    in   second register index; captured when start is accepted
//   bus_sel  out  index of the register driving the bus
//   bus_oe   out  bus_sel is valid; a register drives the bus
//   wr_en    out  one-hot register write enables
//   swp_ld   out  swap holding register loads the bus
//   swp_oe   out  swap holding register drives the bus
//   busy     out  a sequence is in progress
//   done     out  one-cycle completion pulse
//   swap_cnt out  count of completed real swaps (A != B); wraps at 256
module swap_seq #(
    parameter int unsigned AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AW-1:0]     reg_a,
    input  logic [AW-1:0]     reg_b,
    output logic [AW-1:0]     bus_sel,
    output logic              bus_oe,
    output logic [2**AW-1:0]  wr_en,
    output logic              swp_ld,
    output logic              swp_oe,
    output logic              busy,
    output logic              done,
    output logic [7:0]        swap_cnt
);

    localparam int unsigned NR = 2 ** AW;

    typedef enum logic [2:0] {
        StIdle,
        StLoadT,
        StMoveBa,
        StMoveTa,
        StDone
    } state_t;

    state_t        state;
    logic [AW-1:0] a_idx;
    logic [AW-1:0] b_idx;

    function automatic logic [NR-1:0] onehot(input logic [AW-1:0] idx);
        logic [NR-1:0] one;
        one = {{(NR - 1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

    // Outputs are loaded with the decode of the state being entered.
    // All of them default to zero each cycle, so only the asserted ones are
    // listed per transition.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state   <= StIdle;
            a_idx   <= '0;
            b_idx   <= '0;
            bus_sel <= '0;
            bus_oe  <= 1'b0;
            wr_en   <= '0;
            swp_ld  <= 1'b0;
            swp_oe  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            bus_sel <= '0;
            bus_oe  <= 1'b0;
            wr_en   <= '0;
            swp_ld  <= 1'b0;
            swp_oe  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        a_idx <= reg_a;
                        b_idx <= reg_b;
                        busy  <= 1'b1;
                        if (reg_a != reg_b) begin
                            state   <= StLoadT;
                            bus_oe  <= 1'b1;
                            bus_sel <= reg_a;
                            swp_ld  <= 1'b1;
                        end else begin
                            // Self-swap: nothing to move, report completion at once.
                            state <= StDone;
                            done  <= 1'b1;
                        end
                    end
                end
                StLoadT: begin
                    state   <= StMoveBa;
                    busy    <= 1'b1;
                    bus_oe  <= 1'b1;
                    bus_sel <= b_idx;
                    wr_en   <= onehot(a_idx);
                end
                StMoveBa: begin
                    state  <= StMoveTa;
                    busy   <= 1'b1;
                    swp_oe <= 1'b1;
                    wr_en  <= onehot(b_idx);
                end
                StMoveTa: begin
                    state <= StDone;
                    busy  <= 1'b1;
                    done  <= 1'b1;
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

`ifdef SWAP_SEQ_CNT_EN
    logic [7:0] cnt;

    // Only the MOVE_TA -> DONE transition counts; self-swaps enter DONE from IDLE.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == StMoveTa) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign swap_cnt = cnt;
`else
    assign swap_cnt = '0;
`endif

endmodule

// File: tb/tb_swap_seq.sv
module tb_swap_seq;

    localparam int unsigned AW = 4;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  reg_a;
    logic [3:0]  reg_b;
    logic [3:0]  bus_sel;
    logic        bus_oe;
    logic [15:0] wr_en;
    logic        swp_ld;
    logic        swp_oe;
    logic        busy;
    logic        done;
    logic [7:0]  swap_cnt;

    swap_seq #(.AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .reg_a    (reg_a),
        .reg_b    (reg_b),
        .bus_sel  (bus_sel),
        .bus_oe   (bus_oe),
        .wr_en    (wr_en),
        .swp_ld   (swp_ld),
        .swp_oe   (swp_oe),
        .busy     (busy),
        .done     (done),
        .swap_cnt (swap_cnt)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    // Expected bus activity of one cycle.
    typedef struct {
        logic [3:0]  sel;
        logic        oe;
        logic [15:0] wr;
        logic        ld;
        logic        soe;
        logic        bsy;
        logic        dn;
        bit          inc;
    } frame_t;

    frame_t q[$];
    frame_t cur;
    int     cnt_m;
    int     total;
    int     passed;

    function automatic frame_t idle_frame();
        frame_t f;
        f.sel = '0; f.oe = 1'b0; f.wr = '0; f.ld = 1'b0;
        f.soe = 1'b0; f.bsy = 1'b0; f.dn = 1'b0; f.inc = 1'b0;
        return f;
    endfunction

    // A swap request expands into the list of bus transfers it performs,
    // followed by the completion cycle and the mandatory idle cycle.
    task automatic expand(input logic [3:0] a, input logic [3:0] b);
        frame_t f;
        if (a != b) begin
            f = idle_frame(); f.bsy = 1; f.oe = 1; f.sel = a; f.ld = 1;           q.push_back(f);
            f = idle_frame(); f.bsy = 1; f.oe = 1; f.sel = b; f.wr = 16'd1 << a;  q.push_back(f);
            f = idle_frame(); f.bsy = 1; f.soe = 1; f.wr = 16'd1 << b;            q.push_back(f);
            f = idle_frame(); f.bsy = 1; f.dn = 1; f.inc = 1;                     q.push_back(f);
        end else begin
            f = idle_frame(); f.bsy = 1; f.dn = 1;                                q.push_back(f);
        end
        q.push_back(idle_frame());
    endtask

    task automatic model_edge(input logic s, input logic [3:0] a, input logic [3:0] b);
        if (rst) begin
            q.delete();
            cur   = idle_frame();
            cnt_m = 0;
            return;
        end
        if (q.size() == 0 && s) expand(a, b);
        if (q.size() != 0) cur = q.pop_front();
        else cur = idle_frame();
`ifdef SWAP_SEQ_CNT_EN
        if (cur.inc) cnt_m = (cnt_m + 1) % 256;
`endif
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic compare();
        check("outputs", {bus_sel, bus_oe, wr_en, swp_ld, swp_oe, busy, done},
              {cur.sel, cur.oe, cur.wr, cur.ld, cur.soe, cur.bsy, cur.dn});
        check("swap_cnt", swap_cnt, cnt_m);
        check("exclusive", (!(bus_oe && swp_oe) && $onehot0(wr_en)) ? 64'd1 : 64'd0, 64'd1);
    endtask

    task automatic step(input logic s, input logic [3:0] a, input logic [3:0] b);
        start = s;
        reg_a = a;
        reg_b = b;
        @(negedge clk);
        model_edge(s, a, b);
        #1;
        compare();
    endtask

    task automatic async_reset();
        rst = 1'b1;
        #1;
        q.delete();
        cur   = idle_frame();
        cnt_m = 0;
        compare();
    endtask

    initial begin
        logic [3:0] ra;
        logic [3:0] rb;
        total  = 0;
        passed = 0;
        cnt_m  = 0;
        cur    = idle_frame();
        start  = 1'b0;
        reg_a  = '0;
        reg_b  = '0;

        // Power-up reset, checked before any clock edge.
        rst = 1'b1;
        #2;
        compare();
        step(1'b1, 4'd3, 4'd7);
        step(1'b0, 4'd0, 4'd0);
        rst = 1'b0;

        // Directed swap 3 <-> 7.
        step(1'b1, 4'd3, 4'd7);
        check("r32_load_sel", bus_sel, 64'd3);
        check("r32_load_ld", swp_ld, 64'd1);
        step(1'b0, 4'd9, 4'd9);
        check("r32_ba_wr", wr_en, 64'h8);
        step(1'b0, 4'd0, 4'd0);
        check("r32_ta_wr", wr_en, 64'h80);
        step(1'b0, 4'd0, 4'd0);
        check("r32_done", done, 64'd1);
        step(1'b0, 4'd0, 4'd0);

        // Self-swap 5 <-> 5.
        step(1'b1, 4'd5, 4'd5);
        check("r33_done", done, 64'd1);
        check("r33_wr", wr_en, 64'd0);
        step(1'b0, 4'd0, 4'd0);

        // start held high: two sequences in ten cycles.
        for (int i = 0; i < 10; i++) step(1'b1, 4'd1, 4'd2);
        step(1'b0, 4'd0, 4'd0);

        // Reset pulse during MOVE_BA aborts the swap.
        step(1'b1, 4'd1, 4'd2);
        step(1'b0, 4'd0, 4'd0);
        async_reset();
        check("r35_wr", wr_en, 64'd0);
        check("r35_cnt", swap_cnt, 64'd0);
        step(1'b0, 4'd0, 4'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 4'd0);

        // 256 back-to-back real swaps with indices changing mid-sequence.
        for (int i = 0; i < 256 * 5; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = ra ^ 4'($urandom_range(1, 15));
            step(1'b1, ra, rb);
        end
        check("r36_wrap", swap_cnt, 64'd0);
        step(1'b0, 4'd0, 4'd0);

        // Randomized traffic, including self-swaps.
        for (int i = 0; i < 400; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = ($urandom_range(0, 3) == 0) ? ra : 4'($urandom_range(0, 15));
            step(($urandom_range(0, 2) != 0), ra, rb);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
